// File: rtl/uart_pkg.sv
// Shared UART types: frame configuration, receiver states and per-word error flags.
package uart_pkg;

  localparam int unsigned UART_MIN_DBITS = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  typedef struct packed {
    logic brk;
    logic frm;
    logic par;
  } rx_err_t;

  // The reserved encoding 2'b11 behaves as no parity.
  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous first-word fall-through FIFO; head is read straight from storage.
module uart_fifo #(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned ADDR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wptr;
  logic [ADDR_W:0]  r_rptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
  assign w_do_wr = i_wr && (!o_full || i_rd);
  assign w_do_rd = i_rd && !o_empty;

  assign o_rdata = r_mem[r_rptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wptr[ADDR_W-1:0]] <= i_wdata;
        r_wptr                    <= r_wptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime frame format, baud tick generator and an RX FIFO
// holding {break, framing, parity, data} per received frame.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DVSR_WIDTH  = 11,
  parameter int unsigned OVRSAMPLING = 16,
  parameter int unsigned FIFO_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic [1:0]            cfg_dbits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic                  rx,
  input  logic                  rd_uart,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic [2:0]            rd_err,
  output logic                  rx_empty,
  output logic                  rx_full,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int unsigned S_W    = $clog2(OVRSAMPLING);
  localparam int unsigned S_HALF = OVRSAMPLING / 2 - 1;
  localparam int unsigned WORD_W = DATA_BITS + 3;

  logic [1:0]            r_rx_sync;
  logic                  w_rx;
  logic [DVSR_WIDTH-1:0] r_tick_cnt;
  logic                  w_tick;

  rx_state_e             r_state,       w_state_nxt;
  logic [S_W-1:0]        r_s,           w_s_nxt;
  logic [2:0]            r_n,           w_n_nxt;
  logic [DATA_BITS-1:0]  r_data,        w_data_nxt;
  logic [1:0]            r_dbits,       w_dbits_nxt;
  parity_e               r_par,         w_par_nxt;
  logic                  r_stop2,       w_stop2_nxt;
  logic                  r_stop_idx,    w_stop_idx_nxt;
  logic                  r_par_bit,     w_par_bit_nxt;
  logic                  r_par_err,     w_par_err_nxt;
  logic                  r_frm,         w_frm_nxt;
  logic                  r_stop1_low,   w_stop1_low_nxt;
  logic                  r_push,        w_push_nxt;
  logic [DATA_BITS-1:0]  r_word_data,   w_word_data_nxt;
  rx_err_t               r_word_err,    w_word_err_nxt;
  logic                  r_overrun;

  logic [2:0]            w_last_idx;
  logic [3:0]            w_shamt;
  logic [DATA_BITS-1:0]  w_justified;
  logic                  w_stop1_low_final;
  logic                  w_frm_final;
  logic                  w_brk;
  logic [WORD_W-1:0]     w_head;
  logic                  w_full;
  logic                  w_empty;

  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_sync <= '1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx};
    end
  end

  // >= rather than == so a dvsr lowered mid-count cannot leave the counter above it.
  assign w_tick = (r_tick_cnt >= dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_last_idx        = {1'b0, r_dbits} + 3'(UART_MIN_DBITS - 1);
  assign w_shamt           = 4'(DATA_BITS - UART_MIN_DBITS) - {2'b00, r_dbits};
  // Bits were shifted in from the MSB end; align the received word to bit 0.
  assign w_justified       = r_data >> w_shamt;
  assign w_stop1_low_final = r_stop2 ? r_stop1_low : !w_rx;
  assign w_frm_final       = r_frm || !w_rx;
  assign w_brk             = (r_data == '0) && ((r_par == PAR_NONE) || !r_par_bit) &&
                             w_stop1_low_final;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RX_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_data      <= '0;
      r_dbits     <= '0;
      r_par       <= PAR_NONE;
      r_stop2     <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frm       <= 1'b0;
      r_stop1_low <= 1'b0;
      r_push      <= 1'b0;
      r_word_data <= '0;
      r_word_err  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_n         <= w_n_nxt;
      r_data      <= w_data_nxt;
      r_dbits     <= w_dbits_nxt;
      r_par       <= w_par_nxt;
      r_stop2     <= w_stop2_nxt;
      r_stop_idx  <= w_stop_idx_nxt;
      r_par_bit   <= w_par_bit_nxt;
      r_par_err   <= w_par_err_nxt;
      r_frm       <= w_frm_nxt;
      r_stop1_low <= w_stop1_low_nxt;
      r_push      <= w_push_nxt;
      r_word_data <= w_word_data_nxt;
      r_word_err  <= w_word_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_n_nxt         = r_n;
    w_data_nxt      = r_data;
    w_dbits_nxt     = r_dbits;
    w_par_nxt       = r_par;
    w_stop2_nxt     = r_stop2;
    w_stop_idx_nxt  = r_stop_idx;
    w_par_bit_nxt   = r_par_bit;
    w_par_err_nxt   = r_par_err;
    w_frm_nxt       = r_frm;
    w_stop1_low_nxt = r_stop1_low;
    w_push_nxt      = 1'b0;
    w_word_data_nxt = r_word_data;
    w_word_err_nxt  = r_word_err;

    case (r_state)
      RX_IDLE: begin
        if (!w_rx) begin
          w_state_nxt     = RX_START;
          w_s_nxt         = '0;
          w_n_nxt         = '0;
          w_data_nxt      = '0;
          w_dbits_nxt     = cfg_dbits;
          w_par_nxt       = decode_parity(cfg_parity);
          w_stop2_nxt     = cfg_stop2;
          w_stop_idx_nxt  = 1'b0;
          w_par_bit_nxt   = 1'b0;
          w_par_err_nxt   = 1'b0;
          w_frm_nxt       = 1'b0;
          w_stop1_low_nxt = 1'b0;
        end
      end

      RX_START: begin
        if (w_tick) begin
          if (r_s == S_W'(S_HALF)) begin
            w_s_nxt     = '0;
            w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (w_tick) begin
          if (r_s == '1) begin
            w_s_nxt    = '0;
            w_data_nxt = {w_rx, r_data[DATA_BITS-1:1]};
            if (r_n == w_last_idx) begin
              w_state_nxt = (r_par == PAR_NONE) ? RX_STOP : RX_PARITY;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      RX_PARITY: begin
        if (w_tick) begin
          if (r_s == '1) begin
            w_s_nxt       = '0;
            w_par_bit_nxt = w_rx;
            // Unreceived positions of r_data are still zero, so the full-width XOR is exact.
            w_par_err_nxt = ((^r_data) ^ w_rx) != (r_par == PAR_ODD);
            w_state_nxt   = RX_STOP;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (w_tick) begin
          if (r_s == '1) begin
            w_s_nxt = '0;
            if (r_stop2 && !r_stop_idx) begin
              w_stop_idx_nxt  = 1'b1;
              w_stop1_low_nxt = !w_rx;
              w_frm_nxt       = !w_rx;
            end else begin
              w_push_nxt      = 1'b1;
              w_word_data_nxt = w_justified;
              w_word_err_nxt  = '{brk: w_brk, frm: w_frm_final, par: r_par_err};
              w_state_nxt     = w_frm_final ? RX_WAIT_HI : RX_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      RX_WAIT_HI: begin
        if (w_rx) begin
          w_state_nxt = RX_IDLE;
        end
      end

      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  uart_fifo #(
    .WIDTH  (WORD_W),
    .ADDR_W (FIFO_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (r_push),
    .i_wdata ({r_word_err, r_word_data}),
    .i_rd    (rd_uart),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // A new overrun takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (r_push && w_full && !rd_uart) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign rd_data  = w_head[DATA_BITS-1:0];
  assign rd_err   = w_head[DATA_BITS +: 3];
  assign rx_empty = w_empty;
  assign rx_full  = w_full;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: a queue model of received words checked every cycle,
// plus literal expectations after each scenario.
module tb_uart_rx_ext;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] dvsr;
  logic [1:0]  cfg_dbits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        rx;
  logic        rd_uart;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic        rx_empty;
  logic        rx_full;
  logic        overrun;
  logic        clr_overrun;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [10:0] mq[$];
  logic        m_ov;
  bit          settled;
  int          bitclk;

  always #5 clk = ~clk;

  uart_rx_ext #(
    .DATA_BITS   (8),
    .DVSR_WIDTH  (11),
    .OVRSAMPLING (16),
    .FIFO_WIDTH  (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dvsr        (dvsr),
    .cfg_dbits   (cfg_dbits),
    .cfg_parity  (cfg_parity),
    .cfg_stop2   (cfg_stop2),
    .rx          (rx),
    .rd_uart     (rd_uart),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected stored word {brk, frm, par, data} for a frame, from the frame rules alone.
  function automatic logic [10:0] exp_word(input logic [7:0] d, input int nb, input int par,
                                           input logic pb, input logic s1, input logic s2,
                                           input logic two);
    logic [7:0] m;
    logic perr, frm, brk;
    m    = d & (8'hFF >> (8 - nb));
    perr = (par != 0) && (((^m) ^ pb) != (par == 2));
    frm  = !s1 || (two && !s2);
    brk  = (m == 8'h00) && (par == 0 || !pb) && !s1;
    return {brk, frm, perr, m};
  endfunction

  task automatic model_push(input logic [10:0] w);
    if (mq.size() >= 4) m_ov = 1'b1;
    else mq.push_back(w);
  endtask

  always @(negedge clk) begin
    if (settled) begin
      check("empty", rx_empty, mq.size() == 0);
      check("full", rx_full, mq.size() == 4);
      check("overrun", overrun, m_ov);
      if (mq.size() != 0) begin
        check("head_data", rd_data, mq[0][7:0]);
        check("head_err", rd_err, mq[0][10:8]);
      end
    end
  end

  task automatic send_bits(input logic [15:0] bits, input int nb);
    @(posedge clk); #2;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (bitclk) @(posedge clk);
      #2;
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int par, input logic pb,
                            input logic s1, input logic s2, input logic two);
    logic [15:0] bits;
    int k;
    cfg_dbits  = 2'(nb - 5);
    cfg_parity = 2'(par);
    cfg_stop2  = two;
    bits = '1;
    bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nb; i++) begin
      bits[k] = d[i];
      k++;
    end
    if (par != 0) begin
      bits[k] = pb;
      k++;
    end
    bits[k] = s1;
    k++;
    if (two) begin
      bits[k] = s2;
      k++;
    end
    settled = 1'b0;
    send_bits(bits, k);
    model_push(exp_word(d, nb, par, pb, s1, s2, two));
    settled = 1'b1;
    repeat (bitclk) @(posedge clk);
    #2;
  endtask

  task automatic pop();
    @(posedge clk); #2 rd_uart = 1'b1;
    @(posedge clk);
    if (mq.size() != 0) void'(mq.pop_front());
    #2 rd_uart = 1'b0;
  endtask

  task automatic clear_ov();
    @(posedge clk); #2 clr_overrun = 1'b1;
    @(posedge clk);
    m_ov = 1'b0;
    #2 clr_overrun = 1'b0;
  endtask

  initial begin
    logic [15:0] fbits;
    reset_n = 1'b0; rx = 1'b1; rd_uart = 1'b0; clr_overrun = 1'b0;
    dvsr = 11'd4; cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    settled = 1'b0; m_ov = 1'b0; bitclk = 80;

    repeat (3) @(negedge clk);
    check("rst_empty", rx_empty, 1'b1);
    check("rst_full", rx_full, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_data", rd_data, 8'h00);
    check("rst_err", rd_err, 3'b000);
    @(posedge clk); #2 reset_n = 1'b1;
    settled = 1'b1;
    repeat (10) @(posedge clk);

    // 8N1 basic receive and read-back
    send_frame(8'h48, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t1_data", rd_data, 8'h48);
    check("t1_err", rd_err, 3'b000);
    check("t1_nonempty", rx_empty, 1'b0);
    pop();
    check("t1_empty_after_read", rx_empty, 1'b1);
    pop();
    check("t1_pop_when_empty", rx_empty, 1'b1);

    // parity modes
    send_frame(8'h34, 7, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_7e1_data", rd_data, 8'h34);
    check("t2_7e1_err", rd_err, 3'b000);
    pop();
    send_frame(8'h34, 7, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t2_7e1_bad_err", rd_err, 3'b001);
    pop();
    send_frame(8'h71, 8, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_8o1_data", rd_data, 8'h71);
    check("t2_8o1_err", rd_err, 3'b000);
    pop();

    // framing error on second stop bit, then a held break
    send_frame(8'h33, 8, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_8n2_data", rd_data, 8'h33);
    check("t3_8n2_err", rd_err, 3'b010);
    pop();
    settled = 1'b0;
    cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    @(posedge clk); #2 rx = 1'b0;
    repeat (20 * bitclk) @(posedge clk);
    #2 rx = 1'b1;
    model_push(exp_word(8'h00, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    settled = 1'b1;
    repeat (2 * bitclk) @(posedge clk);
    check("t3_brk_data", rd_data, 8'h00);
    check("t3_brk_err", rd_err, 3'b110);
    pop();
    check("t3_single_word", rx_empty, 1'b1);

    // start-bit glitch rejected, then 5N1
    @(posedge clk); #2 rx = 1'b0;
    repeat (25) @(posedge clk);
    #2 rx = 1'b1;
    repeat (2 * bitclk) @(posedge clk);
    check("t4_glitch_no_word", rx_empty, 1'b1);
    send_frame(8'h1F, 5, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t4_5n1_data", rd_data, 8'h1F);
    pop();

    // FIFO overflow, drain, clear
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_full", rx_full, 1'b1);
    check("t5_overrun", overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("t5_read_order", rd_data, 32'(i));
      pop();
    end
    check("t5_drained", rx_empty, 1'b1);
    clear_ov();
    check("t5_clr_overrun", overrun, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_refull", rx_full, 1'b1);

    // push while full with a pop on the push cycle; tick every clock makes timing exact
    dvsr = 11'd0; bitclk = 16;
    cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (4) @(posedge clk);
    #2 settled = 1'b0;
    fbits = {6'h3F, 1'b1, 8'h15, 1'b0};
    fork
      send_bits(fbits, 10);
      begin
        @(posedge clk);
        repeat (155) @(posedge clk);
        #2 rd_uart = 1'b1;
        @(posedge clk);
        #2 rd_uart = 1'b0;
      end
    join
    void'(mq.pop_front());
    model_push(exp_word(8'h15, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0));
    settled = 1'b1;
    repeat (bitclk) @(posedge clk);
    check("t5_pushpop_no_overrun", overrun, 1'b0);
    check("t5_pushpop_full", rx_full, 1'b1);
    check("t5_pushpop_head", rd_data, 8'h12);
    dvsr = 11'd4; bitclk = 80;
    repeat (bitclk) @(posedge clk);

    // overrun again, then reset in the middle of a frame
    send_frame(8'h16, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_pre_overrun", overrun, 1'b1);
    settled = 1'b0;
    fbits = {6'h3F, 1'b1, 8'h5A, 1'b0};
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      rx = fbits[i];
      repeat (bitclk) @(posedge clk);
      #2;
    end
    rx = fbits[4];
    repeat (bitclk / 2) @(posedge clk);
    #2 reset_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_rst_empty", rx_empty, 1'b1);
    check("t6_rst_overrun", overrun, 1'b0);
    check("t6_rst_full", rx_full, 1'b0);
    check("t6_rst_data", rd_data, 8'h00);
    check("t6_rst_err", rd_err, 3'b000);
    @(posedge clk); #2 reset_n = 1'b1;
    mq.delete();
    m_ov = 1'b0;
    settled = 1'b1;
    dvsr = 11'd100; bitclk = 16 * 101;
    repeat (20) @(posedge clk);
    send_frame(8'h47, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_data", rd_data, 8'h47);
    check("t6_err", rd_err, 3'b000);
    pop();
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
